// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
//   state_t  : arbiter mode (free arbitration or debug-locked)
//   port_t   : requester identity, used for the round-robin pointer
//   F3_*     : funct3 size/sign codes understood by the data memory
//   is_aligned(funct3, addr[1:0]) : 1 when the access is naturally aligned
package dmem_arb_pkg;

  typedef enum logic {ARB, DBG_LOCKED} state_t;
  typedef enum logic {PORT_CPU, PORT_DBG} port_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Reserved codes (011, 110, 111) fall through to word alignment.
  function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] addr);
    case (funct3)
      F3_B, F3_BU: is_aligned = 1'b1;
      F3_H, F3_HU: is_aligned = ~addr[0];
      F3_W:        is_aligned = (addr == 2'b00);
      default:     is_aligned = (addr == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dmem_resp_reg.sv
// Registered response slot for one requester port.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   i_fire    : port was granted this cycle
//   i_err     : granted access is misaligned
//   i_we      : granted access is a write
//   i_rdata   : combinational memory read data at the grant
//   o_rvalid  : one-cycle response pulse, the cycle after the grant
//   o_err     : misalignment error, qualified by o_rvalid
//   o_rdata   : read data; holds until the next response to this port
module dmem_resp_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_fire,
  input  logic                  i_err,
  input  logic                  i_we,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  o_rvalid,
  output logic                  o_err,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic                  r_rvalid;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= i_fire;
      r_err    <= i_fire & i_err;
      // Writes and rejected accesses return zero data.
      if (i_fire) r_rdata <= (i_err | i_we) ? '0 : i_rdata;
    end
  end

  assign o_rvalid = r_rvalid;
  assign o_err    = r_err;
  assign o_rdata  = r_rdata;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported byte-addressed data memory.
// One access per cycle, round-robin between the CPU and the debug port,
// with a debug lock that holds the grant on the debug port. Misaligned
// accesses are granted but never written; they return an error response.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   cpu_* / dbg_*            : request (req/we/addr/wdata/funct3), combinational
//                              gnt, registered response (rvalid/rdata/err)
//   dbg_lock                 : keep the grant on the debug port while high
//   mem_wr_en/addr/wdata/funct3 : memory drive, muxed from the granted port
//   mem_rdata                : combinational memory read data
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  input  logic [2:0]               cpu_funct3,
  output logic                     cpu_gnt,
  output logic                     cpu_rvalid,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     cpu_err,
  input  logic                     dbg_req,
  input  logic                     dbg_we,
  input  logic [ADDRESS_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0]    dbg_wdata,
  input  logic [2:0]               dbg_funct3,
  output logic                     dbg_gnt,
  output logic                     dbg_rvalid,
  output logic [DATA_WIDTH-1:0]    dbg_rdata,
  output logic                     dbg_err,
  input  logic                     dbg_lock,
  output logic                     mem_wr_en,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [2:0]               mem_funct3,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  state_t r_state;
  port_t  r_last_gnt;

  logic w_locked;
  logic w_cpu_gnt;
  logic w_dbg_gnt;
  logic w_cpu_aligned;
  logic w_dbg_aligned;
  logic w_sel_aligned;
  logic w_sel_we;

  // The lock only holds while dbg_lock stays high; the release cycle
  // already arbitrates normally.
  assign w_locked = (r_state == DBG_LOCKED) && dbg_lock;

  always_comb begin
    w_cpu_gnt = 1'b0;
    w_dbg_gnt = 1'b0;
    if (!rst) begin
      if (w_locked) begin
        w_dbg_gnt = dbg_req;
      end else if (cpu_req && dbg_req) begin
        if (r_last_gnt == PORT_DBG) w_cpu_gnt = 1'b1;
        else                        w_dbg_gnt = 1'b1;
      end else begin
        w_cpu_gnt = cpu_req;
        w_dbg_gnt = dbg_req;
      end
    end
  end

  assign w_cpu_aligned = is_aligned(cpu_funct3, cpu_addr[1:0]);
  assign w_dbg_aligned = is_aligned(dbg_funct3, dbg_addr[1:0]);

  // Idle cycles present the CPU port to memory.
  assign mem_addr      = w_dbg_gnt ? dbg_addr   : cpu_addr;
  assign mem_wdata     = w_dbg_gnt ? dbg_wdata  : cpu_wdata;
  assign mem_funct3    = w_dbg_gnt ? dbg_funct3 : cpu_funct3;
  assign w_sel_aligned = w_dbg_gnt ? w_dbg_aligned : w_cpu_aligned;
  assign w_sel_we      = w_dbg_gnt ? dbg_we : cpu_we;
  assign mem_wr_en     = (w_cpu_gnt | w_dbg_gnt) & w_sel_we & w_sel_aligned;

  assign cpu_gnt = w_cpu_gnt;
  assign dbg_gnt = w_dbg_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ARB;
      r_last_gnt <= PORT_DBG;
    end else begin
      if (w_dbg_gnt)      r_last_gnt <= PORT_DBG;
      else if (w_cpu_gnt) r_last_gnt <= PORT_CPU;

      case (r_state)
        ARB:        if (w_dbg_gnt && dbg_lock) r_state <= DBG_LOCKED;
        DBG_LOCKED: if (!dbg_lock)             r_state <= ARB;
        default:                               r_state <= ARB;
      endcase
    end
  end

  dmem_resp_reg #(.DATA_WIDTH(DATA_WIDTH)) u_cpu_resp (
    .clk      (clk),
    .rst      (rst),
    .i_fire   (w_cpu_gnt),
    .i_err    (~w_cpu_aligned),
    .i_we     (cpu_we),
    .i_rdata  (mem_rdata),
    .o_rvalid (cpu_rvalid),
    .o_err    (cpu_err),
    .o_rdata  (cpu_rdata)
  );

  dmem_resp_reg #(.DATA_WIDTH(DATA_WIDTH)) u_dbg_resp (
    .clk      (clk),
    .rst      (rst),
    .i_fire   (w_dbg_gnt),
    .i_err    (~w_dbg_aligned),
    .i_we     (dbg_we),
    .i_rdata  (mem_rdata),
    .o_rvalid (dbg_rvalid),
    .o_err    (dbg_err),
    .o_rdata  (dbg_rdata)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a 1 KiB byte memory model, directed
// scenarios with literal expectations, a randomized phase, and a per-cycle
// reference model of grants, memory drive and responses.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_err;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [2:0]  cpu_funct3;
  logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid, dbg_err, dbg_lock;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic [2:0]  dbg_funct3;
  logic        mem_wr_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_funct3;

  int n_chk  = 0;
  int n_fail = 0;

  dmem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_funct3(cpu_funct3), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_funct3(dbg_funct3), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata), .dbg_err(dbg_err), .dbg_lock(dbg_lock),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_byte(input int i);
    logic [31:0] iv;
    iv = i;
    case (i)
      0: init_byte = 8'hEF;
      1: init_byte = 8'hBE;
      2: init_byte = 8'hAD;
      3: init_byte = 8'hDE;
      default: init_byte = iv[7:0] ^ 8'h5A;
    endcase
  endfunction

  // ---------------- memory model (environment) ----------------
  logic [7:0] mem_b [0:1023];
  bit         mem_loaded = 1'b0;
  logic [9:0] ea;
  logic [31:0] ew;

  always_comb begin
    ea = mem_addr[9:0];
    ew = {mem_b[ea + 10'd3], mem_b[ea + 10'd2], mem_b[ea + 10'd1], mem_b[ea]};
    case (mem_funct3)
      3'b000:  mem_rdata = {{24{ew[7]}}, ew[7:0]};
      3'b100:  mem_rdata = {24'h0, ew[7:0]};
      3'b001:  mem_rdata = {{16{ew[15]}}, ew[15:0]};
      3'b101:  mem_rdata = {16'h0, ew[15:0]};
      default: mem_rdata = ew;
    endcase
  end

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 1024; i++) mem_b[i] <= init_byte(i);
      mem_loaded <= 1'b1;
    end else if (mem_wr_en) begin
      mem_b[mem_addr[9:0]] <= mem_wdata[7:0];
      if (mem_funct3[1:0] != 2'b00) mem_b[mem_addr[9:0] + 10'd1] <= mem_wdata[15:8];
      if (mem_funct3[1]) begin
        mem_b[mem_addr[9:0] + 10'd2] <= mem_wdata[23:16];
        mem_b[mem_addr[9:0] + 10'd3] <= mem_wdata[31:24];
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [0:1023];
  bit          armed = 1'b0;
  bit          m_last_dbg, m_locked;
  logic        e_cv, e_ce, e_dv, e_de;
  logic [31:0] e_crd, e_drd;

  function automatic int unsigned acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'd0)      acc_size = 1;
    else if (f3[1:0] == 2'd1) acc_size = 2;
    else                      acc_size = 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
    int unsigned sz;
    logic [31:0] v;
    sz = acc_size(f3);
    v = 0;
    for (int unsigned k = 0; k < sz; k++)
      v = v | (32'(ref_mem[(a[9:0] + k) % 1024]) << (8 * k));
    if (sz < 4 && !f3[2] && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
    logic [31:0] t;
    for (int unsigned k = 0; k < acc_size(f3); k++) begin
      t = wd >> (8 * k);
      ref_mem[(a[9:0] + k) % 1024] = t[7:0];
    end
  endtask

  task automatic model_step();
    logic gc, gd, al, we_s;
    logic [31:0] a, wd, ld;
    logic [2:0] f3;
    if (armed) begin
      chk("cpu_rvalid", cpu_rvalid, e_cv);
      chk("cpu_err",    cpu_err,    e_ce);
      chk("cpu_rdata",  cpu_rdata,  e_crd);
      chk("dbg_rvalid", dbg_rvalid, e_dv);
      chk("dbg_err",    dbg_err,    e_de);
      chk("dbg_rdata",  dbg_rdata,  e_drd);
    end
    if (rst) begin
      gc = 0; gd = 0;
    end else if (m_locked && dbg_lock) begin
      gc = 0; gd = dbg_req;
    end else if (cpu_req && dbg_req) begin
      gc = m_last_dbg; gd = !m_last_dbg;
    end else begin
      gc = cpu_req; gd = dbg_req;
    end
    a    = gd ? dbg_addr : cpu_addr;
    wd   = gd ? dbg_wdata : cpu_wdata;
    f3   = gd ? dbg_funct3 : cpu_funct3;
    we_s = gd ? dbg_we : cpu_we;
    al   = (a % acc_size(f3)) == 0;
    if (armed) begin
      chk("cpu_gnt",    cpu_gnt,    gc);
      chk("dbg_gnt",    dbg_gnt,    gd);
      chk("mem_addr",   mem_addr,   a);
      chk("mem_wdata",  mem_wdata,  wd);
      chk("mem_funct3", mem_funct3, f3);
      chk("mem_wr_en",  mem_wr_en,  (gc | gd) & we_s & al);
    end
    if (rst) begin
      e_cv = 0; e_ce = 0; e_crd = 0; e_dv = 0; e_de = 0; e_drd = 0;
      m_last_dbg = 1; m_locked = 0;
      armed = 1;
    end else begin
      ld = (!al || we_s) ? 32'h0 : ref_load(a, f3);
      e_cv = gc; e_ce = gc & !al;
      e_dv = gd; e_de = gd & !al;
      if (gc) e_crd = ld;
      if (gd) e_drd = ld;
      if (gc | gd) m_last_dbg = gd;
      if (gd && dbg_lock) m_locked = 1;
      else if (!dbg_lock) m_locked = 0;
      if ((gc | gd) && we_s && al) ref_store(a, wd, f3);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(i);
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic rq, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f);
    cpu_req = rq; cpu_we = w; cpu_addr = a; cpu_wdata = d; cpu_funct3 = f;
  endtask

  task automatic set_dbg(input logic rq, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f);
    dbg_req = rq; dbg_we = w; dbg_addr = a; dbg_wdata = d; dbg_funct3 = f;
  endtask

  initial begin
    logic g_c, g_d;
    rst = 1'b1; dbg_lock = 1'b0;
    set_cpu(0, 0, 0, 0, 3'b010);
    set_dbg(0, 0, 0, 0, 3'b010);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cpu_rvalid", cpu_rvalid, 0);
    chk("reset_cpu_rdata",  cpu_rdata,  0);
    chk("reset_mem_wr_en",  mem_wr_en,  0);
    rst = 1'b0;

    // Single CPU word read of preloaded data
    set_cpu(1, 0, 32'h0001_0000, 0, 3'b010);
    #1;
    chk("t1_cpu_gnt", cpu_gnt, 1);
    chk("t1_dbg_gnt", dbg_gnt, 0);
    cyc();
    cpu_req = 0;
    chk("t1_cpu_rvalid", cpu_rvalid, 1);
    chk("t1_cpu_rdata",  cpu_rdata,  32'hDEADBEEF);
    chk("t1_cpu_err",    cpu_err,    0);
    chk("t1_dbg_rvalid", dbg_rvalid, 0);

    // Round-robin under continuous contention, starting from reset
    rst = 1'b1; cyc(); rst = 1'b0;
    set_cpu(1, 0, 32'h300, 0, 3'b010);
    set_dbg(1, 0, 32'h304, 0, 3'b010);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_cpu_gnt", cpu_gnt, (i % 2) == 0);
      chk("t2_dbg_gnt", dbg_gnt, (i % 2) == 1);
      cyc();
      chk("t2_cpu_rvalid", cpu_rvalid, (i % 2) == 0);
      chk("t2_dbg_rvalid", dbg_rvalid, (i % 2) == 1);
    end
    dbg_req = 0;
    #1; chk("t2_cpu_only_gnt", cpu_gnt, 1);
    cyc();

    // Debug lock: write then read back while CPU keeps requesting
    set_dbg(1, 1, 32'h100, 32'h12345678, 3'b010);
    dbg_lock = 1;
    #1;
    chk("t3_cpu_gnt_a", cpu_gnt, 0);
    chk("t3_dbg_gnt_a", dbg_gnt, 1);
    chk("t3_wr_en",     mem_wr_en, 1);
    cyc();
    set_dbg(1, 0, 32'h100, 0, 3'b010);
    #1;
    chk("t3_cpu_gnt_b", cpu_gnt, 0);
    chk("t3_dbg_gnt_b", dbg_gnt, 1);
    cyc();
    chk("t3_dbg_rvalid", dbg_rvalid, 1);
    chk("t3_dbg_rdata",  dbg_rdata,  32'h12345678);
    dbg_req = 0; dbg_lock = 0;
    #1; chk("t3_cpu_gnt_after", cpu_gnt, 1);
    cyc();
    cpu_req = 0;

    // Misaligned writes are rejected
    set_cpu(1, 1, 32'h101, 32'hCAFEBEEF, 3'b001);
    #1;
    chk("t4h_gnt",   cpu_gnt,   1);
    chk("t4h_wr_en", mem_wr_en, 0);
    cyc();
    cpu_req = 0;
    chk("t4h_err",   cpu_err,   1);
    chk("t4h_rdata", cpu_rdata, 0);
    chk("t4h_mem101", mem_b[10'h101], 8'h56);
    chk("t4h_mem102", mem_b[10'h102], 8'h34);
    set_cpu(1, 1, 32'h102, 32'hCAFEBEEF, 3'b010);
    #1;
    chk("t4w_gnt",   cpu_gnt,   1);
    chk("t4w_wr_en", mem_wr_en, 0);
    cyc();
    cpu_req = 0;
    chk("t4w_err",   cpu_err,   1);
    chk("t4w_rdata", cpu_rdata, 0);
    chk("t4w_mem102", mem_b[10'h102], 8'h34);
    chk("t4w_mem103", mem_b[10'h103], 8'h12);
    chk("t4w_mem104", mem_b[10'h104], 8'h5E);

    // Byte write followed by unsigned and signed byte reads
    set_cpu(1, 1, 32'h200, 32'h123456AB, 3'b000);
    #1; chk("t5_wr_en", mem_wr_en, 1);
    cyc();
    chk("t5_wr_rdata", cpu_rdata, 0);
    chk("t5_wr_err",   cpu_err,   0);
    set_cpu(1, 0, 32'h200, 0, 3'b100);
    cyc();
    chk("t5_bu_rdata", cpu_rdata, 32'h0000_00AB);
    set_cpu(1, 0, 32'h200, 0, 3'b000);
    cyc();
    chk("t5_b_rdata", cpu_rdata, 32'hFFFF_FFAB);
    cpu_req = 0;

    // Reset right after a granted read
    set_cpu(1, 0, 32'h300, 0, 3'b010);
    #1; chk("t6_gnt", cpu_gnt, 1);
    cyc();
    rst = 1;
    #1; chk("t6_gnt_in_rst", cpu_gnt, 0);
    cyc();
    chk("t6_cpu_rvalid", cpu_rvalid, 0);
    chk("t6_cpu_rdata",  cpu_rdata,  0);
    chk("t6_cpu_err",    cpu_err,    0);
    chk("t6_dbg_rdata",  dbg_rdata,  0);
    rst = 0;
    set_dbg(1, 0, 32'h304, 0, 3'b010);
    #1;
    chk("t6_tie_cpu_gnt", cpu_gnt, 1);
    chk("t6_tie_dbg_gnt", dbg_gnt, 0);
    cyc();

    // Randomized traffic; fields stay stable until granted or withdrawn
    g_c = cpu_gnt; g_d = 0;
    for (int n = 0; n < 2500; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (cpu_req && (g_c || $urandom_range(0, 7) == 0)) cpu_req = 0;
      if (!cpu_req && $urandom_range(0, 1) == 1)
        set_cpu(1, 1'($urandom), 32'h300 + $urandom_range(0, 63), $urandom, 3'($urandom_range(0, 7)));
      if (dbg_req && (g_d || $urandom_range(0, 7) == 0)) dbg_req = 0;
      if (!dbg_req && $urandom_range(0, 1) == 1)
        set_dbg(1, 1'($urandom), 32'h300 + $urandom_range(0, 63), $urandom, 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 15) == 0) dbg_lock = !dbg_lock;
      #3;
      g_c = cpu_gnt; g_d = dbg_gnt;
      cyc();
    end
    rst = 0; cpu_req = 0; dbg_req = 0; dbg_lock = 0;
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
